// File: rtl/conv_stream_master.sv
// conv_stream_master: serialises captured X/F vectors onto valid/ready streams and gathers Y results into a vector
module conv_stream_master #(
  parameter int DATA_WIDTH_X = 8,
  parameter int DATA_WIDTH_F = 8,
  parameter int X_SIZE       = 8,
  parameter int F_SIZE       = 4,
  parameter int ACC_SIZE     = 18
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start_valid,
  output logic                                     start_ready,
  input  logic [X_SIZE*DATA_WIDTH_X-1:0]           x_vec,
  input  logic [F_SIZE*DATA_WIDTH_F-1:0]           f_vec,
  output logic                                     m_valid_x,
  output logic [DATA_WIDTH_X-1:0]                  m_data_out_x,
  input  logic                                     m_ready_x,
  output logic                                     m_valid_f,
  output logic [DATA_WIDTH_F-1:0]                  m_data_out_f,
  input  logic                                     m_ready_f,
  input  logic                                     s_valid_y,
  input  logic [ACC_SIZE-1:0]                      s_data_in_y,
  output logic                                     s_ready_y,
  output logic [(X_SIZE-F_SIZE+1)*ACC_SIZE-1:0]    y_vec,
  output logic                                     busy,
  output logic                                     done
);
  localparam int Y_SIZE = X_SIZE - F_SIZE + 1;
  localparam int XC = $clog2(X_SIZE + 1);
  localparam int FC = $clog2(F_SIZE + 1);
  localparam int YC = $clog2(Y_SIZE + 1);
  localparam logic [XC-1:0] X_END = XC'(X_SIZE);
  localparam logic [FC-1:0] F_END = FC'(F_SIZE);
  localparam logic [YC-1:0] Y_END = YC'(Y_SIZE);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [X_SIZE*DATA_WIDTH_X-1:0] x_q, x_d;
  logic [F_SIZE*DATA_WIDTH_F-1:0] f_q, f_d;
  logic [Y_SIZE*ACC_SIZE-1:0]     y_q, y_d;
  logic [XC-1:0]                  x_cnt_q, x_cnt_d;
  logic [FC-1:0]                  f_cnt_q, f_cnt_d;
  logic [YC-1:0]                  y_cnt_q, y_cnt_d;
  logic                           accept, x_beat, f_beat, y_beat;
  assign accept = start_valid && start_ready;
  assign x_beat = m_valid_x && m_ready_x;
  assign f_beat = m_valid_f && m_ready_f;
  assign y_beat = s_valid_y && s_ready_y;
  assign y_vec  = y_q;
  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  // Next state: a job ends once all three counters reach their terminal counts after this edge
  always_comb begin
    state_d = (state_q == IDLE) ? (accept ? RUN : IDLE) :
              (state_q == RUN)  ? ((x_cnt_d == X_END && f_cnt_d == F_END && y_cnt_d == Y_END) ? DONE : RUN) :
              IDLE;
  end
  // Outputs: channels are only live in RUN; data is the element selected by each counter
  always_comb begin
    start_ready  = state_q == IDLE;
    busy         = state_q != IDLE;
    done         = state_q == DONE;
    m_valid_x    = state_q == RUN && x_cnt_q < X_END;
    m_valid_f    = state_q == RUN && f_cnt_q < F_END;
    s_ready_y    = state_q == RUN && y_cnt_q < Y_END;
    m_data_out_x = '0;
    m_data_out_f = '0;
    for (int i = 0; i < X_SIZE; i++)
      if (x_cnt_q == XC'(i)) m_data_out_x = x_q[i*DATA_WIDTH_X +: DATA_WIDTH_X];
    for (int i = 0; i < F_SIZE; i++)
      if (f_cnt_q == FC'(i)) m_data_out_f = f_q[i*DATA_WIDTH_F +: DATA_WIDTH_F];
  end
  // Datapath next state: capture on accept, otherwise advance counters and fill Y slots per beat
  always_comb begin
    x_d     = accept ? x_vec : x_q;
    f_d     = accept ? f_vec : f_q;
    x_cnt_d = accept ? '0 : x_cnt_q + XC'(x_beat);
    f_cnt_d = accept ? '0 : f_cnt_q + FC'(f_beat);
    y_cnt_d = accept ? '0 : y_cnt_q + YC'(y_beat);
    y_d     = accept ? '0 : y_q;
    for (int k = 0; k < Y_SIZE; k++)
      if (y_beat && y_cnt_q == YC'(k)) y_d[k*ACC_SIZE +: ACC_SIZE] = s_data_in_y;
  end
  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q     <= '0;
      f_q     <= '0;
      y_q     <= '0;
      x_cnt_q <= '0;
      f_cnt_q <= '0;
      y_cnt_q <= '0;
    end else begin
      x_q     <= x_d;
      f_q     <= f_d;
      y_q     <= y_d;
      x_cnt_q <= x_cnt_d;
      f_cnt_q <= f_cnt_d;
      y_cnt_q <= y_cnt_d;
    end
  end
endmodule

// File: tb/tb_conv_stream_master.sv
// tb_conv_stream_master: directed scenarios for the stream master with a bench-side stand-in for the engine
module tb_conv_stream_master;
  localparam int DWX = 8;
  localparam int DWF = 8;
  localparam int XS  = 8;
  localparam int FS  = 4;
  localparam int ACC = 18;
  localparam int YS  = XS - FS + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_valid = 1'b0;
  logic start_ready;
  logic [XS*DWX-1:0] x_vec = '0;
  logic [FS*DWF-1:0] f_vec = '0;
  logic m_valid_x, m_valid_f, s_ready_y, busy, done;
  logic [DWX-1:0] m_data_out_x;
  logic [DWF-1:0] m_data_out_f;
  logic m_ready_x = 1'b0;
  logic m_ready_f = 1'b0;
  logic s_valid_y = 1'b0;
  logic [ACC-1:0] s_data_in_y = '0;
  logic [YS*ACC-1:0] y_vec;

  conv_stream_master #(.DATA_WIDTH_X(DWX), .DATA_WIDTH_F(DWF), .X_SIZE(XS), .F_SIZE(FS), .ACC_SIZE(ACC)) dut (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
    .x_vec(x_vec), .f_vec(f_vec),
    .m_valid_x(m_valid_x), .m_data_out_x(m_data_out_x), .m_ready_x(m_ready_x),
    .m_valid_f(m_valid_f), .m_data_out_f(m_data_out_f), .m_ready_f(m_ready_f),
    .s_valid_y(s_valid_y), .s_data_in_y(s_data_in_y), .s_ready_y(s_ready_y),
    .y_vec(y_vec), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DWX-1:0] xq[$];
  logic [DWF-1:0] fq[$];
  int xcyc[$];
  int fcyc[$];
  int done_cyc, done_cnt, stall_err, y_refused, sr_seen;
  logic busy_after, st_rdy;
  logic [ACC-1:0] ysrc[8];
  int yn;
  logic [31:0] xr_pat, fr_pat;
  int sv_cyc;
  logic [XS*DWX-1:0] alt_x;
  logic [FS*DWF-1:0] alt_f;

  function automatic logic [XS*DWX-1:0] mk_x(input int b, input int s);
    logic [XS*DWX-1:0] r;
    for (int i = 0; i < XS; i++) r[i*DWX +: DWX] = DWX'(b + s*i);
    return r;
  endfunction

  function automatic logic [FS*DWF-1:0] mk_f(input int b, input int s);
    logic [FS*DWF-1:0] r;
    for (int i = 0; i < FS; i++) r[i*DWF +: DWF] = DWF'(b + s*i);
    return r;
  endfunction

  function automatic logic [YS*ACC-1:0] mk_y(input int b, input int s);
    logic [YS*ACC-1:0] r;
    for (int k = 0; k < YS; k++) r[k*ACC +: ACC] = ACC'(b + s*k);
    return r;
  endfunction

  task automatic set_ysrc(input int b, input int s, input int n);
    for (int k = 0; k < 8; k++) ysrc[k] = ACC'(b + s*k);
    yn = n;
  endtask

  task automatic start_job(input logic [XS*DWX-1:0] xv, input logic [FS*DWF-1:0] fv);
    @(posedge clk); #1;
    x_vec = xv;
    f_vec = fv;
    start_valid = 1'b1;
    s_valid_y = 1'b0;
    @(negedge clk);
    st_rdy = start_ready;
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  // drives cycles N+1.. and logs beats, stalls and done; stops two cycles after done or on abort
  task automatic run_job(input int maxc, input int abort_x);
    int yi;
    logic yb, px_st, pf_st, stop;
    logic [DWX-1:0] px;
    logic [DWF-1:0] pf;
    xq.delete(); fq.delete(); xcyc.delete(); fcyc.delete();
    done_cyc = -1; done_cnt = 0; stall_err = 0; y_refused = 0; sr_seen = -1; busy_after = 1'b1;
    yi = 0; yb = 1'b0; px_st = 1'b0; pf_st = 1'b0; px = '0; pf = '0; stop = 1'b0;
    for (int c = 1; c <= maxc && !stop; c++) begin
      if (yb) yi++;
      m_ready_x   = (c > 32) ? 1'b1 : xr_pat[c-1];
      m_ready_f   = (c > 32) ? 1'b1 : fr_pat[c-1];
      s_valid_y   = yi < yn;
      s_data_in_y = (yi < yn) ? ysrc[yi] : '0;
      start_valid = (c == sv_cyc);
      if (c == sv_cyc) begin
        x_vec = alt_x;
        f_vec = alt_f;
      end
      @(negedge clk);
      if (px_st && (!m_valid_x || m_data_out_x !== px)) stall_err++;
      if (pf_st && (!m_valid_f || m_data_out_f !== pf)) stall_err++;
      px_st = m_valid_x && !m_ready_x; px = m_data_out_x;
      pf_st = m_valid_f && !m_ready_f; pf = m_data_out_f;
      if (m_valid_x && m_ready_x) begin xq.push_back(m_data_out_x); xcyc.push_back(c); end
      if (m_valid_f && m_ready_f) begin fq.push_back(m_data_out_f); fcyc.push_back(c); end
      yb = s_valid_y && s_ready_y;
      if (s_valid_y && !s_ready_y && busy && !done) y_refused++;
      if (c == sv_cyc) sr_seen = int'(start_ready);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c == done_cyc + 1) busy_after = busy;
      if (abort_x > 0 && xq.size() == abort_x) stop = 1'b1;
      else if (done_cyc >= 0 && c == done_cyc + 2) stop = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    start_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({start_ready, m_valid_x, m_valid_f, s_ready_y, busy, done} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 100000", {start_ready, m_valid_x, m_valid_f, s_ready_y, busy, done});
    end
    checks++;
    if (y_vec !== '0) begin errors++; $display("FAIL reset_yvec got %h want 0", y_vec); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_free_flow;
    xr_pat = '1; fr_pat = '1; sv_cyc = -1;
    set_ysrc(100, 1, 5);
    start_job(mk_x(1, 1), mk_f(1, 1));
    checks++;
    if (st_rdy !== 1'b1) begin errors++; $display("FAIL ff_start_ready got %b want 1", st_rdy); end
    run_job(40, 0);
    checks++;
    if (xq.size() != 8 || fq.size() != 4) begin
      errors++; $display("FAIL ff_beats got x=%0d f=%0d want x=8 f=4", xq.size(), fq.size());
    end
    for (int i = 0; i < xq.size() && i < 8; i++) begin
      checks++;
      if (xq[i] !== DWX'(i + 1) || xcyc[i] != i + 1) begin
        errors++; $display("FAIL ff_x%0d got %0d@c%0d want %0d@c%0d", i, xq[i], xcyc[i], i + 1, i + 1);
      end
    end
    for (int i = 0; i < fq.size() && i < 4; i++) begin
      checks++;
      if (fq[i] !== DWF'(i + 1) || fcyc[i] != i + 1) begin
        errors++; $display("FAIL ff_f%0d got %0d@c%0d want %0d@c%0d", i, fq[i], fcyc[i], i + 1, i + 1);
      end
    end
    checks++;
    if (y_vec !== mk_y(100, 1)) begin errors++; $display("FAIL ff_yvec got %h want %h", y_vec, mk_y(100, 1)); end
    checks++;
    if (done_cnt != 1 || done_cyc != 9) begin
      errors++; $display("FAIL ff_done got cnt=%0d cyc=%0d want cnt=1 cyc=9", done_cnt, done_cyc);
    end
    checks++;
    if (busy_after !== 1'b0) begin errors++; $display("FAIL ff_busy_after got %b want 0", busy_after); end
  endtask

  task automatic test_backpressure;
    xr_pat = 32'h5555_5555; fr_pat = 32'hFFFF_FFC0; sv_cyc = -1;
    set_ysrc(200, 1, 5);
    start_job(mk_x(16, 1), mk_f(240, 1));
    run_job(60, 0);
    checks++;
    if (stall_err != 0) begin errors++; $display("FAIL bp_stable got %0d violations want 0", stall_err); end
    checks++;
    if (xq.size() != 8 || fq.size() != 4) begin
      errors++; $display("FAIL bp_beats got x=%0d f=%0d want x=8 f=4", xq.size(), fq.size());
    end
    for (int i = 0; i < xq.size() && i < 8; i++) begin
      checks++;
      if (xq[i] !== DWX'(16 + i) || xcyc[i] != 2*i + 1) begin
        errors++; $display("FAIL bp_x%0d got %0d@c%0d want %0d@c%0d", i, xq[i], xcyc[i], 16 + i, 2*i + 1);
      end
    end
    for (int i = 0; i < fq.size() && i < 4; i++) begin
      checks++;
      if (fq[i] !== DWF'(240 + i) || fcyc[i] != 7 + i) begin
        errors++; $display("FAIL bp_f%0d got %0d@c%0d want %0d@c%0d", i, fq[i], fcyc[i], 240 + i, 7 + i);
      end
    end
    checks++;
    if (done_cyc != 16 || done_cnt != 1) begin
      errors++; $display("FAIL bp_done got cnt=%0d cyc=%0d want cnt=1 cyc=16", done_cnt, done_cyc);
    end
  endtask

  task automatic test_y_overflow;
    xr_pat = 32'hFFFF_FFE0; fr_pat = '1; sv_cyc = -1;
    set_ysrc(7, 1, 6);
    start_job(mk_x(1, 1), mk_f(1, 1));
    run_job(60, 0);
    checks++;
    if (y_vec !== mk_y(7, 1)) begin errors++; $display("FAIL yo_yvec got %h want %h", y_vec, mk_y(7, 1)); end
    checks++;
    if (y_refused < 1) begin errors++; $display("FAIL yo_refused got %0d refusals want >=1", y_refused); end
    checks++;
    if (done_cyc != 14 || done_cnt != 1) begin
      errors++; $display("FAIL yo_done got cnt=%0d cyc=%0d want cnt=1 cyc=14", done_cnt, done_cyc);
    end
  endtask

  task automatic test_start_ignored;
    xr_pat = '1; fr_pat = '1; sv_cyc = 3;
    alt_x = mk_x(170, 0); alt_f = mk_f(85, 0);
    set_ysrc(1, 1, 5);
    start_job(mk_x(1, 1), mk_f(1, 1));
    run_job(40, 0);
    checks++;
    if (sr_seen != 0) begin errors++; $display("FAIL si_start_ready got %0d want 0", sr_seen); end
    checks++;
    if (xq.size() != 8 || fq.size() != 4) begin
      errors++; $display("FAIL si_beats got x=%0d f=%0d want x=8 f=4", xq.size(), fq.size());
    end
    for (int i = 0; i < xq.size() && i < 8; i++) begin
      checks++;
      if (xq[i] !== DWX'(i + 1)) begin errors++; $display("FAIL si_x%0d got %0d want %0d", i, xq[i], i + 1); end
    end
    checks++;
    if (fq.size() == 4 && fq[3] !== DWF'(4)) begin errors++; $display("FAIL si_f3 got %0d want 4", fq[3]); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL si_done got %0d want 1", done_cnt); end
    sv_cyc = -1;
    start_job(alt_x, alt_f);
    checks++;
    if (st_rdy !== 1'b1) begin errors++; $display("FAIL si_second_ready got %b want 1", st_rdy); end
    run_job(40, 0);
    checks++;
    if (xq.size() != 8 || xq[0] !== 8'd170 || fq.size() != 4 || fq[0] !== 8'd85) begin
      errors++; $display("FAIL si_second_data got x0=%0d f0=%0d want 170 85", xq.size() ? xq[0] : 8'd0, fq.size() ? fq[0] : 8'd0);
    end
  endtask

  task automatic test_reset_mid;
    xr_pat = '1; fr_pat = '1; sv_cyc = -1;
    set_ysrc(50, 1, 5);
    start_job(mk_x(1, 1), mk_f(1, 1));
    run_job(40, 3);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({start_ready, m_valid_x, m_valid_f, s_ready_y, busy, done} !== 6'b100000) begin
      errors++;
      $display("FAIL rm_ctrl got %b want 100000", {start_ready, m_valid_x, m_valid_f, s_ready_y, busy, done});
    end
    checks++;
    if (y_vec !== '0) begin errors++; $display("FAIL rm_yvec got %h want 0", y_vec); end
    s_valid_y = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    set_ysrc(60, 2, 5);
    start_job(mk_x(21, 1), mk_f(31, 1));
    run_job(40, 0);
    checks++;
    if (xq.size() != 8 || xq[0] !== 8'd21 || xq[7] !== 8'd28) begin
      errors++; $display("FAIL rm_fresh_x got n=%0d x0=%0d want n=8 x0=21 x7=28", xq.size(), xq.size() ? xq[0] : 8'd0);
    end
    checks++;
    if (fq.size() != 4 || fq[0] !== 8'd31) begin
      errors++; $display("FAIL rm_fresh_f got n=%0d f0=%0d want n=4 f0=31", fq.size(), fq.size() ? fq[0] : 8'd0);
    end
    checks++;
    if (y_vec !== mk_y(60, 2) || done_cnt != 1) begin
      errors++; $display("FAIL rm_fresh_y got %h done=%0d want %h done=1", y_vec, done_cnt, mk_y(60, 2));
    end
  endtask

  // stand-in for the engine: valid-mode correlation of the captured vectors
  task automatic engine_model(input logic [XS*DWX-1:0] xv, input logic [FS*DWF-1:0] fv);
    int s;
    for (int k = 0; k < YS; k++) begin
      s = 0;
      for (int j = 0; j < FS; j++) s += int'($signed(xv[(k+j)*DWX +: DWX])) * int'($signed(fv[j*DWF +: DWF]));
      ysrc[k] = s[ACC-1:0];
    end
    yn = YS;
  endtask

  task automatic test_back_to_back;
    xr_pat = '1; fr_pat = '1; sv_cyc = -1;
    engine_model(mk_x(1, 1), mk_f(1, 0));
    start_job(mk_x(1, 1), mk_f(1, 0));
    run_job(40, 0);
    checks++;
    if (y_vec !== mk_y(10, 4) || done_cnt != 1) begin
      errors++; $display("FAIL b2b_pos got %h done=%0d want %h done=1", y_vec, done_cnt, mk_y(10, 4));
    end
    engine_model(mk_x(-1, -1), mk_f(1, 0));
    start_job(mk_x(-1, -1), mk_f(1, 0));
    checks++;
    if (y_vec !== '0) begin errors++; $display("FAIL b2b_clear got %h want 0", y_vec); end
    run_job(40, 0);
    checks++;
    if (y_vec !== mk_y(-10, -4) || done_cnt != 1) begin
      errors++; $display("FAIL b2b_neg got %h done=%0d want %h done=1", y_vec, done_cnt, mk_y(-10, -4));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_free_flow();
    test_backpressure();
    test_y_overflow();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
